// File: rtl/pipeline_stage_register_pkg.sv
// Shared definitions for the pipeline stage register: stage states and
// default bus widths. Optional skid feature: PIPELINE_STAGE_SKID_BUFFER_EN.
package pipeline_stage_register_pkg;

  localparam int DEFAULT_CONTROL_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH    = 133;
  localparam int DEFAULT_COUNT_WIDTH   = 16;

  // EMPTY: no instruction held; FULL: output register valid;
  // SKID: output register valid and the skid slot also occupied.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipeline_stage_register_skid_slot.sv
// One-entry skid slot (control + data + valid bit) used by the pipeline
// stage register. Compiled only when PIPELINE_STAGE_SKID_BUFFER_EN is defined.
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
module pipeline_skid_slot
  import pipeline_stage_register_pkg::*;
#(
  parameter int CONTROL_WIDTH = DEFAULT_CONTROL_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_i,
  input  logic                     clear_i,
  input  logic [CONTROL_WIDTH-1:0] control_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  output logic                     valid_o,
  output logic [CONTROL_WIDTH-1:0] control_o,
  output logic [DATA_WIDTH-1:0]    data_o
);

  logic                     valid_q;
  logic [CONTROL_WIDTH-1:0] control_q;
  logic [DATA_WIDTH-1:0]    data_q;

  // Occupancy bit: clear (drain or flush) wins over load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  // Payload capture.
  // NOTE: the payload is deliberately not reset; valid_q alone says whether it means anything.
  always_ff @(posedge clk) begin
    if (load_i) begin
      control_q <= control_i;
      data_q    <= data_i;
    end
  end

  assign valid_o   = valid_q;
  assign control_o = control_q;
  assign data_o    = data_q;

endmodule
`endif

// File: rtl/pipeline_stage_register.sv
// Pipeline stage register with valid/ready handshake, flush, and a saturating
// stall counter. Defining PIPELINE_STAGE_SKID_BUFFER_EN adds a one-entry skid
// slot and makes ready_out a registered signal.
module pipeline_stage_register
  import pipeline_stage_register_pkg::*;
#(
  parameter int CONTROL_WIDTH = DEFAULT_CONTROL_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [CONTROL_WIDTH-1:0] control_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     flush,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [CONTROL_WIDTH-1:0] control_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [COUNT_WIDTH-1:0]   stall_count
);

  stage_state_e             state_q, state_d;
  logic [CONTROL_WIDTH-1:0] control_q, control_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     accept;
  logic                     drain;

  assign valid_out = (state_q != EMPTY);
  assign accept    = valid_in && ready_out;
  assign drain     = valid_out && ready_in;

`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
  logic                     skid_load;
  logic                     skid_clear;
  logic                     skid_valid;
  logic [CONTROL_WIDTH-1:0] skid_control;
  logic [DATA_WIDTH-1:0]    skid_data;

  pipeline_skid_slot #(
    .CONTROL_WIDTH (CONTROL_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_skid_slot (
    .clk       (clk),
    .reset     (reset),
    .load_i    (skid_load),
    .clear_i   (skid_clear),
    .control_i (control_in),
    .data_i    (data_in),
    .valid_o   (skid_valid),
    .control_o (skid_control),
    .data_o    (skid_data)
  );

  // Registered ready: upstream may send whenever the skid slot is free.
  assign ready_out = !skid_valid;
`else
  // Combinational ready: room if empty, or if the held item leaves this cycle.
  assign ready_out = !valid_out || ready_in;
`endif

  // Next-state and datapath capture; flush overrides every handshake.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    control_d = control_q;
    data_d    = data_q;
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
      skid_clear = 1'b1;
`endif
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = FULL;
            control_d = control_in;
            data_d    = data_in;
          end
        end
        FULL: begin
          if (drain) begin
            if (accept) begin
              control_d = control_in;
              data_d    = data_in;
            end else begin
              state_d = EMPTY;
            end
          end
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
          else if (accept) begin
            skid_load = 1'b1;
            state_d   = SKID;
          end
`endif
        end
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
        SKID: begin
          if (drain) begin
            state_d    = FULL;
            control_d  = skid_control;
            data_d     = skid_data;
            skid_clear = 1'b1;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stall counter: counts held-but-blocked cycles, saturating at all-ones.
  always_comb begin
    count_d = count_q;
    if (valid_out && !ready_in && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q   <= EMPTY;
      control_q <= '0;
      data_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      control_q <= control_d;
      data_q    <= data_d;
      count_q   <= count_d;
    end
  end

  // A bubble must never assert write enables downstream.
  assign control_out = valid_out ? control_q : '0;
  assign data_out    = data_q;
  assign stall_count = count_q;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Self-checking bench for pipeline_stage_register. Expectations follow the
// build: PIPELINE_STAGE_SKID_BUFFER_EN selects the skid-slot behaviour.
module tb_pipeline_stage_register;

  localparam int CW = 5;
  localparam int DW = 133;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          ready_out;
  logic [CW-1:0] control_in;
  logic [DW-1:0] data_in;
  logic          flush;
  logic          valid_out;
  logic          ready_in;
  logic [CW-1:0] control_out;
  logic [DW-1:0] data_out;
  logic [NW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  pipeline_stage_register dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .control_in  (control_in),
    .data_in     (data_in),
    .flush       (flush),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .control_out (control_out),
    .data_out    (data_out),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          vin;
    logic [CW-1:0] cin;
    logic [DW-1:0] din;
    logic          fl;
    logic          rin;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [NW-1:0] es;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic f, input logic rin);
    reset      = r;
    valid_in   = v;
    control_in = c;
    data_in    = d;
    flush      = f;
    ready_in   = rin;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [CW-1:0] ec,
                            input logic [DW-1:0] ed);
    check({tag, ".valid_out"}, DW'(valid_out), DW'(ev));
    check({tag, ".control_out"}, DW'(control_out), DW'(ec));
    check({tag, ".data_out"}, data_out, ed);
  endtask

  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

  initial begin
    // rst_n vin cin din fl rin | ev ec ed es
    vecs[0]  = '{1'b0, 1'b0, 5'h00, 133'h0,    1'b0, 1'b0, 1'b0, 5'h00, 133'h0,    16'd0};
    vecs[1]  = '{1'b1, 1'b1, 5'h1F, 133'h1234, 1'b0, 1'b1, 1'b1, 5'h1F, 133'h1234, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 5'h00, 133'h0,    1'b0, 1'b1, 1'b0, 5'h00, 133'h1234, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 5'h0A, 133'hABCD, 1'b0, 1'b0, 1'b1, 5'h0A, 133'hABCD, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 5'h00, 133'h0,    1'b0, 1'b0, 1'b1, 5'h0A, 133'hABCD, 16'd1};
    vecs[5]  = '{1'b1, 1'b0, 5'h00, 133'h0,    1'b0, 1'b0, 1'b1, 5'h0A, 133'hABCD, 16'd2};
    vecs[6]  = '{1'b1, 1'b0, 5'h00, 133'h0,    1'b0, 1'b0, 1'b1, 5'h0A, 133'hABCD, 16'd3};
    vecs[7]  = '{1'b1, 1'b1, 5'h03, 133'h5555, 1'b0, 1'b1, 1'b1, 5'h03, 133'h5555, 16'd3};
    vecs[8]  = '{1'b1, 1'b1, 5'h1F, 133'h9999, 1'b1, 1'b1, 1'b0, 5'h00, 133'h5555, 16'd3};
    vecs[9]  = '{1'b1, 1'b1, 5'h11, 133'h7777, 1'b0, 1'b0, 1'b1, 5'h11, 133'h7777, 16'd3};
    vecs[10] = '{1'b1, 1'b0, 5'h00, 133'h0,    1'b1, 1'b0, 1'b0, 5'h00, 133'h7777, 16'd4};
    vecs[11] = '{1'b1, 1'b0, 5'h00, 133'h0,    1'b0, 1'b1, 1'b0, 5'h00, 133'h7777, 16'd4};
    vecs[12] = '{1'b1, 1'b1, 5'h10, ALL1,      1'b0, 1'b1, 1'b1, 5'h10, ALL1,      16'd4};
    vecs[13] = '{1'b0, 1'b1, 5'h1F, 133'h3333, 1'b1, 1'b0, 1'b0, 5'h00, 133'h0,    16'd0};
    vecs[14] = '{1'b1, 1'b0, 5'h00, 133'h0,    1'b0, 1'b0, 1'b0, 5'h00, 133'h0,    16'd0};

    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    step();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].vin, vecs[i].cin, vecs[i].din, vecs[i].fl, vecs[i].rin);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ed);
      check($sformatf("vec%0d.stall_count", i), DW'(stall_count), DW'(vecs[i].es));
    end

    // Ready is high in the first cycle after reset release.
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("ready_after_reset", DW'(ready_out), DW'(1'b1));

    // Accept A while downstream stalls; ready then depends on the build.
    drive(1'b1, 1'b1, 5'h01, 133'hA, 1'b0, 1'b0);
    step();
    check_outs("fill_a", 1'b1, 5'h01, 133'hA);
    drive(1'b1, 1'b1, 5'h02, 133'hB, 1'b0, 1'b0);
    #1;
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
    check("ready_full_stalled", DW'(ready_out), DW'(1'b1));
`else
    check("ready_full_stalled", DW'(ready_out), DW'(1'b0));
`endif
    // Offer B while stalled: taken into skid, or held off.
    step();
    check_outs("stall_b", 1'b1, 5'h01, 133'hA);
    check("ready_after_b", DW'(ready_out), DW'(1'b0));
    // Release the stall: A has been presented, B follows on the next cycle.
`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
    drive(1'b1, 1'b0, 5'h00, 133'h0, 1'b0, 1'b1);
`else
    drive(1'b1, 1'b1, 5'h02, 133'hB, 1'b0, 1'b1);
`endif
    step();
    check_outs("drain_to_b", 1'b1, 5'h02, 133'hB);
    check("ready_after_drain", DW'(ready_out), DW'(1'b1));
    drive(1'b1, 1'b0, 5'h00, 133'h0, 1'b0, 1'b1);
    step();
    check_outs("drain_b", 1'b0, 5'h00, 133'hB);

`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
    // Flush with the skid occupied empties both entries.
    drive(1'b1, 1'b1, 5'h04, 133'hC, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 5'h05, 133'hD, 1'b0, 1'b0);
    step();
    check("skid_full_ready", DW'(ready_out), DW'(1'b0));
    drive(1'b1, 1'b0, 5'h00, 133'h0, 1'b1, 1'b0);
    step();
    check_outs("flush_skid", 1'b0, 5'h00, 133'hC);
    check("ready_after_flush", DW'(ready_out), DW'(1'b1));
    drive(1'b1, 1'b0, 5'h00, 133'h0, 1'b0, 1'b1);
    step();
    check_outs("after_flush_skid", 1'b0, 5'h00, 133'hC);
`endif

    // Reset mid-stall (skid occupied in the skid build).
    drive(1'b1, 1'b1, 5'h06, 133'hE, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 5'h07, 133'hF, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 5'h08, 133'h10, 1'b0, 1'b0);
    step();
    check_outs("reset_mid_stall", 1'b0, 5'h00, 133'h0);
    check("reset_mid_stall.stall_count", DW'(stall_count), DW'(0));
    drive(1'b1, 1'b0, 5'h00, 133'h0, 1'b0, 1'b1);
    #1;
    check("ready_after_release", DW'(ready_out), DW'(1'b1));
    step();
    check_outs("empty_after_release", 1'b0, 5'h00, 133'h0);

    // Long stall drives the counter into saturation.
    drive(1'b1, 1'b1, 5'h09, 133'h77, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'h00, 133'h0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check("stall_saturate", DW'(stall_count), DW'(16'hFFFF));
    check_outs("stall_saturate_hold", 1'b1, 5'h09, 133'h77);
    step();
    check("stall_saturate_more", DW'(stall_count), DW'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
